// File: rtl/uart_rx.sv
// 8N1 serial receiver: the start edge is found on the synchronized line, and each bit is
// sampled at mid-bit. Received bytes go out through a one-entry valid/ready register.
module uart_rx #(
    parameter int CLK_HZ    = 65_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DIVISOR   = 6771,
    parameter int PKT_LEN   = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rx_in,
    input  logic       ready_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       overrun_out,
    output logic       busy_out
);
    // An out-of-range DIVISOR falls back to the rate derived from the clock and baud settings.
    localparam int          DIV    = (DIVISOR >= 4) ? DIVISOR : CLK_HZ / BAUD_RATE;
    localparam logic [31:0] RELOAD = 32'(DIV - 1);
    localparam logic [31:0] HALF   = 32'(DIV / 2 - 1);
    localparam logic [3:0]  LAST   = 4'(PKT_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic        rx_meta, rx_s;
    logic [2:0]  state;
    logic [31:0] count;
    logic [3:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tick, done_ok, done_bad;

    assign tick     = (state == S_START || state == S_DATA || state == S_STOP) && count == 32'd0;
    assign done_ok  = state == S_STOP && tick && rx_s;
    assign done_bad = state == S_STOP && tick && !rx_s;
    assign busy_out = state != S_IDLE;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= S_IDLE;
            count   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (tick)
                count <= RELOAD;
            else if (count != 32'd0)
                count <= count - 32'd1;
            case (state)
                S_IDLE: if (!rx_s) begin
                    // First sample lands half a bit in, so every later tick is mid-bit.
                    count <= HALF;
                    shreg <= '0;
                    state <= S_START;
                end
                S_START: if (tick) begin
                    bit_idx <= '0;
                    state   <= rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: if (tick) begin
                    shreg[bit_idx[2:0]] <= rx_s;
                    bit_idx             <= bit_idx + 4'd1;
                    if (bit_idx == LAST)
                        state <= S_STOP;
                end
                S_STOP:  if (tick) state <= rx_s ? S_IDLE : S_BREAK;
                S_BREAK: if (rx_s) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Holding register: a completion with a consumer in the same cycle replaces the old byte.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_out      <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            frame_err_out <= done_bad;
            overrun_out   <= 1'b0;
            if (done_ok) begin
                if (valid_out && !ready_in) begin
                    overrun_out <= 1'b1;
                end else begin
                    data_out  <= shreg;
                    valid_out <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames driven onto the line; a negedge monitor records
// consumed bytes and error pulses, and these are compared to what each frame should produce.
module tb_uart_rx;
    localparam int DIV = 16;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       rx_in = 1'b1;
    logic       ready_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, frame_err_out, overrun_out, busy_out;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] got[$];

    uart_rx #(.CLK_HZ(160), .BAUD_RATE(10), .DIVISOR(DIV), .PKT_LEN(8)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_in(rx_in), .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out), .frame_err_out(frame_err_out),
        .overrun_out(overrun_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (valid_out && ready_in) got.push_back(data_out);
        if (frame_err_out) fe_cnt++;
        if (overrun_out) ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            tick(DIV);
        end
        rx_in = stop_bit;
        tick(DIV);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [31:0] v;
        v = 32'hxxxxxxxx;
        if (got.size() != 0) v = {24'd0, got.pop_front()};
        check(tag, v, {24'd0, exp});
    endtask

    initial begin
        int fe0, ov0, exp_fe, hold;
        logic [7:0] b;
        logic bad;

        // reset state
        tick(3);
        check("rst_valid", {31'd0, valid_out}, 0);
        check("rst_data", {24'd0, data_out}, 0);
        check("rst_busy", {31'd0, busy_out}, 0);
        check("rst_fe", {31'd0, frame_err_out}, 0);
        rst_n_in = 1'b1;
        tick(3);

        // 0xA5 with exact latency: valid first seen in cycle 155 after the start edge
        ready_in = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(154);
                check("a5_valid_early", {31'd0, valid_out}, 0);
                check("a5_busy_stop", {31'd0, busy_out}, 1);
                tick(1);
                check("a5_valid", {31'd0, valid_out}, 1);
                check("a5_data", {24'd0, data_out}, 32'hA5);
                check("a5_busy_idle", {31'd0, busy_out}, 0);
                tick(1);
                check("a5_consumed", {31'd0, valid_out}, 0);
            end
        join
        expect_byte("a5_byte", 8'hA5);
        check("a5_no_err", 32'(fe_cnt - fe0 + ov_cnt - ov0), 0);

        // glitch shorter than half a bit
        fe0 = fe_cnt; ov0 = ov_cnt;
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(2);
        check("glitch_busy", {31'd0, busy_out}, 1);
        tick(10);
        check("glitch_idle", {31'd0, busy_out}, 0);
        check("glitch_valid", {31'd0, valid_out}, 0);
        check("glitch_no_err", 32'(fe_cnt - fe0 + ov_cnt - ov0), 0);
        check("glitch_no_byte", 32'(got.size()), 0);

        // framing error with a held-low line, then a good frame
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        tick(40);
        rx_in = 1'b1;
        tick(6);
        check("fe_pulses", 32'(fe_cnt - fe0), 1);
        check("fe_valid", {31'd0, valid_out}, 0);
        check("fe_busy", {31'd0, busy_out}, 0);
        check("fe_no_byte", 32'(got.size()), 0);
        send_frame(8'h81, 1'b1);
        tick(2);
        expect_byte("fe_next_byte", 8'h81);

        // overrun: 0x22 dropped while 0x11 waits
        ready_in = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(4);
        check("ovr_pulses", 32'(ov_cnt - ov0), 1);
        check("ovr_valid", {31'd0, valid_out}, 1);
        check("ovr_data", {24'd0, data_out}, 32'h11);
        ready_in = 1'b1;
        tick(1);
        check("ovr_cleared", {31'd0, valid_out}, 0);
        expect_byte("ovr_byte", 8'h11);
        check("ovr_dropped", 32'(got.size()), 0);

        // consumption in the completion cycle loads the new byte without overrun
        ready_in = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(154);
                ready_in = 1'b1;
                tick(1);
                ready_in = 1'b0;
            end
        join
        check("sim_valid", {31'd0, valid_out}, 1);
        check("sim_data", {24'd0, data_out}, 32'h22);
        check("sim_no_ovr", 32'(ov_cnt - ov0), 0);
        expect_byte("sim_first", 8'h11);
        ready_in = 1'b1;
        tick(1);
        expect_byte("sim_second", 8'h22);

        // async reset during data bit 3 with a byte pending
        ready_in = 1'b0;
        send_frame(8'h99, 1'b1);
        tick(2);
        check("rstm_pending", {31'd0, valid_out}, 1);
        fe0 = fe_cnt; ov0 = ov_cnt;
        fork
            send_frame(8'h77, 1'b1);
            begin
                tick(70);
                check("rstm_busy_before", {31'd0, busy_out}, 1);
                rst_n_in = 1'b0;
                #1;
                check("rstm_valid", {31'd0, valid_out}, 0);
                check("rstm_data", {24'd0, data_out}, 0);
                check("rstm_busy", {31'd0, busy_out}, 0);
            end
        join
        tick(3);
        rst_n_in = 1'b1;
        tick(3);
        check("rstm_no_pulse", 32'(fe_cnt - fe0 + ov_cnt - ov0), 0);
        check("rstm_no_byte", 32'(got.size()), 0);
        ready_in = 1'b1;
        send_frame(8'h5A, 1'b1);
        tick(1);
        expect_byte("rstm_after", 8'h5A);

        // randomized frames against the model: good stop -> byte delivered, bad stop -> one error
        fe0 = fe_cnt; ov0 = ov_cnt; exp_fe = 0;
        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(b, !bad);
            if (bad) begin
                exp_fe++;
                hold = int'($urandom_range(0, 30));
                tick(hold);
                rx_in = 1'b1;
                tick(int'($urandom_range(4, 10)));
                check("rnd_no_byte", 32'(got.size()), 0);
            end else begin
                tick(int'($urandom_range(0, 6)));
                expect_byte($sformatf("rnd_byte%0d", n), b);
            end
        end
        tick(4);
        check("rnd_fe_total", 32'(fe_cnt - fe0), 32'(exp_fe));
        check("rnd_no_ovr", 32'(ov_cnt - ov0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
